alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single combinational ALU between NREQ requesters (e.g. EX stage, branch-target unit).
//  Each requester uses a valid/ready request channel and a valid/ready response channel.
//  Round-robin grant; the ALU output is registered, giving 1-cycle latency and 1 op/cycle throughput.
//  Illegal op codes are trapped before they reach the ALU.
// PARAMETERS
//  NREQ   2    number of requesters (>=2)
//  IDW    $clog2(NREQ)  width of internal grant id (derived, localparam)
// PORTS
//  clk          in   1          single clock, rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  req_valid    in   NREQ       requester i has an op pending
//  req_ready    out  NREQ       op of requester i accepted this cycle
//  req_op       in   NREQ*4     per-requester 4-bit ALU control code
//  req_srca     in   NREQ*32    per-requester operand A
//  req_srcb     in   NREQ*32    per-requester operand B
//  rsp_valid    out  NREQ       result for requester i is held
//  rsp_ready    in   NREQ       requester i consumes its result
//  rsp_result   out  32         result, shared bus, qualified by rsp_valid
//  rsp_zero     out  1          result==0 flag from ALU
//  rsp_err      out  1          1 = op code was illegal
//  alu_control  out  4          to ALU
//  alu_srca     out  32         to ALU
//  alu_srcb     out  32         to ALU
//  alu_result   in   32         from ALU, same cycle
//  alu_zero     in   1          from ALU, same cycle
//  grant_count  out  32         total accepted ops, wraps at 2^32
// BEHAVIOUR
//  - Reset (async assert, clock-synchronous deassert externally): rsp_valid_q=0, rsp_id_q=0, rsp_result=0,
//    rsp_zero=0, rsp_err=0, rr_ptr=NREQ-1 (requester 0 wins first), grant_count=0.
//  - Slot free: free = !rsp_valid_q | rsp_ready[rsp_id_q]. No grant when !free.
//  - Grant: when free, winner = first i with req_valid[i], searching from rr_ptr+1 modulo NREQ.
//    req_ready[winner]=1, all other bits 0. req_ready may depend on req_valid; req_valid must not
//    depend on req_ready.
//  - Grant cycle N: ALU driven with the winner's op/operands. At the N edge capture alu_result,
//    alu_zero, id and err into the response register. rsp_valid[id]=1 from N+1 (latency 1).
//  - Legal ops: 0000 add, 0001 sub, 0010 and, 0011 or, 0101 slt(signed). Any other code is illegal:
//    ALU driven 0000/0/0; response result=0, zero=0, err=1; still granted and counted.
//  - No grant: ALU driven 0000/0/0. Never drive an illegal code to the ALU.
//  - Response held stable (result/zero/err/id) until rsp_ready[id]. rsp_ready of other bits ignored.
//  - Pop and grant in the same cycle are allowed: back-to-back 1 op/cycle, including same requester.
//  - rr_ptr <= winner on each grant only; unchanged otherwise. grant_count += 1 per grant.
//  - Requester must hold req_op/srca/srcb stable while req_valid & !req_ready.
//  - Reset mid-operation: held response is discarded; requesters reissue. No X on outputs after reset.
// STRUCTURE
//  - alu_pkg: alu_op_e enum (ALU_ADD=4'b0000, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT=4'b0101),
//    function is_legal_op(logic [3:0]) -> bit. Shared with decoder and ALU.
//  - Sub-module rr_arbiter #(N): req vector + ptr -> one-hot grant + index; purely combinational.
//  - Top: response register, rr_ptr, counter and ALU operand mux.
// TESTING
//  1 Reset, then req0 add 5+7 -> req_ready[0] same cycle; next cycle rsp_valid=01, result=12, zero=0.
//  2 Both valid continuously, rsp_ready=11: grants alternate 0,1,0,1; one response per cycle;
//    grant_count=4 after 4 cycles.
//  3 req1 sub 3-3 with rsp_ready[1]=0 for 3 cycles: result=0, zero=1 held stable; req0 stalls
//    (req_ready=00) until pop, then is granted in the pop cycle.
//  4 req0 op=4'b0111: rsp_err=1, result=0; alu_control never 4'b0111; next op add 1+1 gives 2, err=0.
//  5 slt 0xFFFF_FFFF vs 1 -> result=1; slt 1 vs 0xFFFF_FFFF -> result=0.
//  6 Assert rst_n=0 with response held: rsp_valid=0 immediately; after release req1+req0 valid
//    -> req0 granted first.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU op codes and the legality check used by the arbiter, decoder and ALU.
package alu_arbiter_pkg;

  localparam int DW = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_SLT = 4'b0101
  } alu_op_e;

  function automatic bit is_legal_op(logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: is_legal_op = 1'b1;
      default:                                   is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side request/response channels of the shared-ALU arbiter.
interface alu_arbiter_if #(parameter int NREQ = 2);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][3:0]  req_op;
  logic [NREQ-1:0][31:0] req_srca;
  logic [NREQ-1:0][31:0] req_srcb;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [31:0]           rsp_result;
  logic                  rsp_zero;
  logic                  rsp_err;

  modport master (
    output req_valid, req_op, req_srca, req_srcb, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_srca, req_srcb, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

endinterface

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin pick: first requester after i_ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] w_pos;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    for (int k = 1; k <= N; k++) begin
      w_pos = IW'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_pos]) begin
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters; round-robin grant,
// registered response (1-cycle latency), illegal op codes trapped before the ALU.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic [3:0]    o_alu_control,
  output logic [DW-1:0] o_alu_srca,
  output logic [DW-1:0] o_alu_srcb,
  input  logic [DW-1:0] i_alu_result,
  input  logic          i_alu_zero,
  output logic [31:0]   o_grant_count
);

  localparam int IDW = $clog2(NREQ);

  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [DW-1:0]   r_rsp_result;
  logic            r_rsp_zero;
  logic            r_rsp_err;
  logic [IDW-1:0]  r_rr_ptr;
  logic [31:0]     r_grant_count;

  logic            w_pop;
  logic            w_free;
  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic [3:0]      w_op;
  logic            w_legal;

  // A held response blocks new grants unless its owner pops it this cycle.
  assign w_pop  = r_rsp_valid & bus.rsp_ready[r_rsp_id];
  assign w_free = ~r_rsp_valid | w_pop;
  assign w_req  = w_free ? bus.req_valid : '0;

  rr_arbiter #(.N(NREQ)) u_rr (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign bus.req_ready  = w_gnt;
  assign w_op           = bus.req_op[w_idx];
  assign w_legal        = is_legal_op(w_op);
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.rsp_err    = r_rsp_err;
  assign o_grant_count  = r_grant_count;

  // Idle or illegal cycles park the ALU on a harmless add of zeros.
  always_comb begin
    o_alu_control = 4'b0000;
    o_alu_srca    = '0;
    o_alu_srcb    = '0;
    if (w_any && w_legal) begin
      o_alu_control = w_op;
      o_alu_srca    = bus.req_srca[w_idx];
      o_alu_srcb    = bus.req_srcb[w_idx];
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (r_rsp_valid) bus.rsp_valid[r_rsp_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_result  <= '0;
      r_rsp_zero    <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rr_ptr      <= IDW'(NREQ - 1);
      r_grant_count <= '0;
    end else if (w_any) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_id      <= w_idx;
      r_rsp_result  <= w_legal ? i_alu_result : '0;
      r_rsp_zero    <= w_legal ? i_alu_zero : 1'b0;
      r_rsp_err     <= ~w_legal;
      r_rr_ptr      <= w_idx;
      r_grant_count <= r_grant_count + 32'd1;
    end else if (w_pop) begin
      r_rsp_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model checked every cycle.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NREQ = 2;

  logic        clk;
  logic        rst_n;
  logic [3:0]  alu_control;
  logic [31:0] alu_srca;
  logic [31:0] alu_srcb;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] grant_count;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_arbiter_if #(.NREQ(NREQ)) bus ();

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .o_alu_control (alu_control),
    .o_alu_srca    (alu_srca),
    .o_alu_srcb    (alu_srcb),
    .i_alu_result  (alu_result),
    .i_alu_zero    (alu_zero),
    .o_grant_count (grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit legal(logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5};
  endfunction

  // External ALU the DUT drives
  assign alu_result = alu_ref(alu_control, alu_srca, alu_srcb);
  assign alu_zero   = (alu_result == 32'd0);

  // Reference model: the held response plus who was served last
  bit          m_valid;
  int          m_id;
  logic [31:0] m_result;
  bit          m_zero;
  bit          m_err;
  int          m_last;
  logic [31:0] m_count;

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_result = 0; m_zero = 0; m_err = 0;
    m_last = NREQ - 1; m_count = 0;
  endtask

  function automatic int predict_winner();
    if (m_valid && !bus.rsp_ready[m_id]) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      if (bus.req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_update();
    int w;
    logic [3:0] op;
    w = predict_winner();
    if (!rst_n) return;
    if (w >= 0) begin
      op       = bus.req_op[w];
      m_err    = !legal(op);
      m_result = legal(op) ? alu_ref(op, bus.req_srca[w], bus.req_srcb[w]) : 32'd0;
      m_zero   = legal(op) && (m_result == 32'd0);
      m_valid  = 1;
      m_id     = w;
      m_last   = w;
      m_count  = m_count + 1;
    end else if (m_valid && bus.rsp_ready[m_id]) begin
      m_valid = 0;
    end
  endtask

  task automatic model_compare();
    int w;
    logic [1:0] exp_ready;
    logic [1:0] exp_rv;
    if (!rst_n) begin
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_count", grant_count, 32'd0);
      return;
    end
    w = predict_winner();
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    exp_rv = '0;
    if (m_valid) exp_rv[m_id] = 1'b1;
    chk("m_req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("m_rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    chk("m_count", grant_count, m_count);
    if (m_valid) begin
      chk("m_result", bus.rsp_result, m_result);
      chk("m_zero", 32'(bus.rsp_zero), 32'(m_zero));
      chk("m_err", 32'(bus.rsp_err), 32'(m_err));
    end
    if (w >= 0 && legal(bus.req_op[w])) begin
      chk("m_alu_ctl", 32'(alu_control), 32'(bus.req_op[w]));
      chk("m_alu_a", alu_srca, bus.req_srca[w]);
      chk("m_alu_b", alu_srcb, bus.req_srcb[w]);
    end else begin
      chk("m_alu_ctl", 32'(alu_control), 32'd0);
      chk("m_alu_a", alu_srca, 32'd0);
      chk("m_alu_b", alu_srcb, 32'd0);
    end
  endtask

  task automatic mid();
    @(negedge clk);
    model_compare();
    #1;
  endtask

  task automatic edge_();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drv(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_op[r]   = op;
    bus.req_srca[r] = a;
    bus.req_srcb[r] = b;
  endtask

  logic [1:0] seq [4];

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_op    = '0;
    bus.req_srca  = '0;
    bus.req_srcb  = '0;
    model_reset();
    repeat (3) begin mid(); edge_(); end
    rst_n = 1'b1;
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_count", grant_count, 32'd0);

    // single add, latency 1
    bus.rsp_ready = 2'b11;
    drv(0, ALU_ADD, 32'd5, 32'd7);
    bus.req_valid = 2'b01;
    mid();
    chk("t1_ready", 32'(bus.req_ready), 32'd1);
    chk("t1_alu_a", alu_srca, 32'd5);
    edge_();
    bus.req_valid = 2'b00;
    mid();
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t1_result", bus.rsp_result, 32'd12);
    chk("t1_zero", 32'(bus.rsp_zero), 32'd0);
    edge_();

    // both requesting: alternate, last winner was 0
    drv(0, ALU_ADD, 32'd10, 32'd20);
    drv(1, ALU_OR, 32'hF0, 32'h0F);
    bus.req_valid = 2'b11;
    seq = '{2'b10, 2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("t2_ready", 32'(bus.req_ready), 32'(seq[i]));
      if (i == 1) chk("t2_or_result", bus.rsp_result, 32'hFF);
      if (i == 2) chk("t2_add_result", bus.rsp_result, 32'd30);
      edge_();
    end
    bus.req_valid = 2'b00;
    mid();
    chk("t2_count", grant_count, 32'd5);
    chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    edge_();

    // held response stalls the other requester
    drv(1, ALU_SUB, 32'd3, 32'd3);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b01;
    mid();
    chk("t3_ready1", 32'(bus.req_ready), 32'd2);
    edge_();
    drv(0, ALU_ADD, 32'd1, 32'd2);
    bus.req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t3_stall", 32'(bus.req_ready), 32'd0);
      chk("t3_hold_valid", 32'(bus.rsp_valid), 32'd2);
      chk("t3_hold_result", bus.rsp_result, 32'd0);
      chk("t3_hold_zero", 32'(bus.rsp_zero), 32'd1);
      edge_();
    end
    bus.rsp_ready = 2'b11;
    mid();
    chk("t3_pop_grant", 32'(bus.req_ready), 32'd1);
    edge_();
    bus.req_valid = 2'b00;
    mid();
    chk("t3_result", bus.rsp_result, 32'd3);
    edge_();

    // illegal op trapped, then back-to-back legal op from same requester
    drv(0, 4'b0111, 32'd9, 32'd9);
    bus.req_valid = 2'b01;
    mid();
    chk("t4_ready", 32'(bus.req_ready), 32'd1);
    chk("t4_alu_ctl", 32'(alu_control), 32'd0);
    chk("t4_alu_a", alu_srca, 32'd0);
    edge_();
    drv(0, ALU_ADD, 32'd1, 32'd1);
    mid();
    chk("t4_err", 32'(bus.rsp_err), 32'd1);
    chk("t4_err_result", bus.rsp_result, 32'd0);
    chk("t4_b2b_ready", 32'(bus.req_ready), 32'd1);
    edge_();
    bus.req_valid = 2'b00;
    mid();
    chk("t4_result", bus.rsp_result, 32'd2);
    chk("t4_noerr", 32'(bus.rsp_err), 32'd0);
    edge_();

    // signed set-less-than
    drv(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    bus.req_valid = 2'b01;
    mid();
    edge_();
    drv(0, ALU_SLT, 32'd1, 32'hFFFF_FFFF);
    mid();
    chk("t5_slt_neg", bus.rsp_result, 32'd1);
    edge_();
    bus.req_valid = 2'b00;
    mid();
    chk("t5_slt_pos", bus.rsp_result, 32'd0);
    chk("t5_slt_zero", 32'(bus.rsp_zero), 32'd1);
    chk("t5_count", grant_count, 32'd11);
    edge_();

    // reset while a response is held
    drv(1, ALU_ADD, 32'd4, 32'd4);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b00;
    mid();
    edge_();
    bus.req_valid = 2'b00;
    mid();
    chk("t6_held", 32'(bus.rsp_valid), 32'd2);
    chk("t6_held_result", bus.rsp_result, 32'd8);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t6_async_result", bus.rsp_result, 32'd0);
    edge_();
    mid();
    edge_();
    rst_n = 1'b1;
    drv(0, ALU_ADD, 32'd2, 32'd2);
    drv(1, ALU_ADD, 32'd6, 32'd6);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    mid();
    chk("t6_first_grant", 32'(bus.req_ready), 32'd1);
    edge_();
    bus.req_valid = 2'b00;
    mid();
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t6_result", bus.rsp_result, 32'd4);
    chk("t6_count", grant_count, 32'd1);
    edge_();
    mid();
    edge_();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
